// File: rtl/register_read_stage_if.sv
// Bundle between the operand-fetch stage and its neighbours.
// It carries the instruction handshake, the write-back port and the operand bundle handshake.
interface register_read_stage_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [31:0]       instr;
    logic              instr_valid;
    logic              instr_ready;
    logic              wb_en;
    logic [ADDR_W-1:0] wb_address;
    logic [DATA_W-1:0] wb_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [ADDR_W-1:0] out_address;
    logic [2:0]        ALU_operation;
    logic              illegal;

    modport master (
        output instr, instr_valid, wb_en, wb_address, wb_data, out_ready,
        input  instr_ready, out_valid, rs_data, rt_data, out_address, ALU_operation, illegal
    );

    modport slave (
        input  instr, instr_valid, wb_en, wb_address, wb_data, out_ready,
        output instr_ready, out_valid, rs_data, rt_data, out_address, ALU_operation, illegal
    );
endinterface

// File: rtl/register_read_stage.sv
// R-format operand fetch: 32x32 register file with one read port; rs and rt are read on consecutive cycles.
// Latency: accept at edge N, out_valid after N+2. Throughput is one instruction per 4 cycles.
// Backpressure: HOLD keeps the bundle until out_ready. instr_ready is high only in IDLE.
module register_read_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input logic                  clk,
    input logic                  reset_input,
    register_read_stage_if.slave bus
);
    localparam int NREG = 1 << ADDR_W;

    typedef enum logic [1:0] {IDLE, READ_RS, READ_RT, HOLD} state_t;

    state_t            state_q, state_d;
    logic              ready_q;
    logic              accept;
    logic              out_valid_q;
    logic              illegal_q;
    logic [2:0]        alu_q;
    logic [ADDR_W-1:0] rs_addr_q, rt_addr_q, rd_q;
    logic [DATA_W-1:0] rs_data_q, rt_data_q;
    logic [DATA_W-1:0] regs [NREG];

    logic              wb_hit;
    logic              wb_hits_rs, wb_hits_rt;
    logic [DATA_W-1:0] rs_read, rt_read;
    logic [2:0]        alu_dec;
    logic              illegal_dec;

    // shamt is not used by any supported operation
    logic unused_shamt;
    assign unused_shamt = ^bus.instr[10:6];

    assign wb_hit     = bus.wb_en && (bus.wb_address != '0);
    assign wb_hits_rs = wb_hit && (bus.wb_address == rs_addr_q);
    assign wb_hits_rt = wb_hit && (bus.wb_address == rt_addr_q);

    // Single read port, bypassed so a same-cycle write-back is never missed
    always_comb begin
        rs_read = '0;
        rt_read = '0;
        if (wb_hits_rs)
            rs_read = bus.wb_data;
        else if (rs_addr_q != '0)
            rs_read = regs[rs_addr_q];
        if (wb_hits_rt)
            rt_read = bus.wb_data;
        else if (rt_addr_q != '0)
            rt_read = regs[rt_addr_q];
    end

    always_comb begin
        alu_dec     = 3'b000;
        illegal_dec = 1'b0;
        if (bus.instr[31:26] != 6'd0) begin
            illegal_dec = 1'b1;
        end else begin
            case (bus.instr[5:0])
                6'h20:   alu_dec = 3'b000;
                6'h22:   alu_dec = 3'b001;
                6'h24:   alu_dec = 3'b010;
                6'h25:   alu_dec = 3'b011;
                6'h2A:   alu_dec = 3'b100;
                default: illegal_dec = 1'b1;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (ready_q && bus.instr_valid) begin
                    accept  = 1'b1;
                    state_d = READ_RS;
                end
            end
            READ_RS: state_d = READ_RT;
            READ_RT: state_d = HOLD;
            HOLD:    if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_input) begin
            for (int i = 0; i < NREG; i++)
                regs[i] <= '0;
        end else if (wb_hit) begin
            regs[bus.wb_address] <= bus.wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_input) begin
            state_q     <= IDLE;
            ready_q     <= 1'b0;
            out_valid_q <= 1'b0;
            illegal_q   <= 1'b0;
            alu_q       <= '0;
            rs_addr_q   <= '0;
            rt_addr_q   <= '0;
            rd_q        <= '0;
            rs_data_q   <= '0;
            rt_data_q   <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d == IDLE);
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        rs_addr_q <= bus.instr[25:21];
                        rt_addr_q <= bus.instr[20:16];
                        rd_q      <= bus.instr[15:11];
                        alu_q     <= alu_dec;
                        illegal_q <= illegal_dec;
                    end
                end
                READ_RS: rs_data_q <= rs_read;
                READ_RT: begin
                    rt_data_q   <= rt_read;
                    out_valid_q <= 1'b1;
                    if (wb_hits_rs) rs_data_q <= bus.wb_data;
                end
                HOLD: begin
                    if (wb_hits_rs) rs_data_q <= bus.wb_data;
                    if (wb_hits_rt) rt_data_q <= bus.wb_data;
                    if (bus.out_ready) out_valid_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.instr_ready   = ready_q;
    assign bus.out_valid     = out_valid_q;
    assign bus.rs_data       = rs_data_q;
    assign bus.rt_data       = rt_data_q;
    assign bus.out_address   = rd_q;
    assign bus.ALU_operation = alu_q;
    assign bus.illegal       = illegal_q;
endmodule

// File: tb/tb_register_read_stage.sv
// Directed bench for register_read_stage: preload, latency, reset abort, bypass,
// backpressure coherence, register 0 and illegal decode.
module tb_register_read_stage;
    logic clk;
    logic reset_input;
    int   checks;
    int   errors;

    register_read_stage_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    register_read_stage #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk         (clk),
        .reset_input (reset_input),
        .bus         (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wb_write(input logic [4:0] addr, input logic [31:0] data);
        bus.wb_en      = 1'b1;
        bus.wb_address = addr;
        bus.wb_data    = data;
        step();
        bus.wb_en      = 1'b0;
    endtask

    task automatic accept(input logic [31:0] word);
        bus.instr       = word;
        bus.instr_valid = 1'b1;
        step();
        bus.instr_valid = 1'b0;
    endtask

    task automatic chk_bundle(input string tag, input logic [31:0] rs, input logic [31:0] rt,
                              input logic [4:0] rd, input logic [2:0] op, input logic ill);
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        chk({tag, "_rs"}, bus.rs_data, rs);
        chk({tag, "_rt"}, bus.rt_data, rt);
        chk({tag, "_rd"}, 32'(bus.out_address), 32'(rd));
        chk({tag, "_op"}, 32'(bus.ALU_operation), 32'(op));
        chk({tag, "_ill"}, 32'(bus.illegal), 32'(ill));
    endtask

    // Accept, expect the bundle after two more edges, then consume it with out_ready high
    task automatic run_instr(input string tag, input logic [31:0] word, input logic [31:0] rs,
                             input logic [31:0] rt, input logic [4:0] rd, input logic [2:0] op,
                             input logic ill);
        bus.out_ready = 1'b1;
        accept(word);
        chk({tag, "_busy"}, 32'(bus.instr_ready), 32'd0);
        step();
        chk({tag, "_early"}, 32'(bus.out_valid), 32'd0);
        step();
        chk_bundle(tag, rs, rt, rd, op, ill);
        step();
        chk({tag, "_done"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_rdy"}, 32'(bus.instr_ready), 32'd1);
    endtask

    initial begin
        checks          = 0;
        errors          = 0;
        reset_input     = 1'b0;
        bus.instr       = '0;
        bus.instr_valid = 1'b0;
        bus.wb_en       = 1'b0;
        bus.wb_address  = '0;
        bus.wb_data     = '0;
        bus.out_ready   = 1'b0;

        step();
        step();
        chk("rst_ready", 32'(bus.instr_ready), 32'd0);
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_rs", bus.rs_data, 32'd0);
        chk("rst_op", 32'(bus.ALU_operation), 32'd0);
        chk("rst_ill", 32'(bus.illegal), 32'd0);
        reset_input = 1'b1;
        step();
        chk("rel_ready", 32'(bus.instr_ready), 32'd1);

        // Basic add after preload
        wb_write(5'd1, 32'd31);
        wb_write(5'd2, 32'd47);
        run_instr("add", 32'h0022_1820, 32'd31, 32'd47, 5'd3, 3'b000, 1'b0);

        // Reset in READ_RT abandons the instruction and clears the file
        accept(32'h0022_1820);
        step();
        reset_input = 1'b0;
        step();
        chk("abort_valid", 32'(bus.out_valid), 32'd0);
        chk("abort_ready", 32'(bus.instr_ready), 32'd0);
        reset_input = 1'b1;
        step();
        chk("abort_rel", 32'(bus.instr_ready), 32'd1);
        step();
        chk("abort_nobundle", 32'(bus.out_valid), 32'd0);
        run_instr("cleared", 32'h0022_1820, 32'd0, 32'd0, 5'd3, 3'b000, 1'b0);

        // Bypass: write-back to rs in the READ_RS cycle
        wb_write(5'd1, 32'd31);
        wb_write(5'd2, 32'd47);
        bus.out_ready = 1'b1;
        accept(32'h0022_1822);
        bus.wb_en      = 1'b1;
        bus.wb_address = 5'd1;
        bus.wb_data    = 32'd100;
        step();
        bus.wb_en = 1'b0;
        step();
        chk_bundle("byp", 32'd100, 32'd47, 5'd3, 3'b001, 1'b0);
        step();
        chk("byp_done", 32'(bus.out_valid), 32'd0);

        // Backpressure in HOLD with a write-back to rt and a new instruction offered
        bus.out_ready = 1'b0;
        accept(32'h0022_1824);
        step();
        step();
        chk_bundle("hold0", 32'd100, 32'd47, 5'd3, 3'b010, 1'b0);
        bus.wb_en       = 1'b1;
        bus.wb_address  = 5'd2;
        bus.wb_data     = 32'd9;
        bus.instr       = 32'h0022_2825;
        bus.instr_valid = 1'b1;
        step();
        bus.wb_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk_bundle("hold", 32'd100, 32'd9, 5'd3, 3'b010, 1'b0);
            chk("hold_ready", 32'(bus.instr_ready), 32'd0);
            step();
        end
        bus.instr_valid = 1'b0;
        bus.out_ready   = 1'b1;
        step();
        chk("hold_done", 32'(bus.out_valid), 32'd0);
        chk("hold_rdy", 32'(bus.instr_ready), 32'd1);
        step();
        chk("hold_idle", 32'(bus.instr_ready), 32'd1);

        // Register 0 stays zero, including for write-backs while holding
        wb_write(5'd0, 32'hFFFF_FFFF);
        bus.out_ready = 1'b0;
        accept(32'h0000_2020);
        step();
        step();
        chk_bundle("r0", 32'd0, 32'd0, 5'd4, 3'b000, 1'b0);
        wb_write(5'd0, 32'hFFFF_FFFF);
        chk("r0_hold_rs", bus.rs_data, 32'd0);
        chk("r0_hold_rt", bus.rt_data, 32'd0);
        bus.out_ready = 1'b1;
        step();
        chk("r0_done", 32'(bus.out_valid), 32'd0);

        // Illegal encodings still flow through the handshake
        run_instr("ill_funct", 32'h0022_1808, 32'd100, 32'd9, 5'd3, 3'b000, 1'b1);
        run_instr("ill_opc", 32'h8C22_1820, 32'd100, 32'd9, 5'd3, 3'b000, 1'b1);
        run_instr("slt", 32'h0022_182A, 32'd100, 32'd9, 5'd3, 3'b100, 1'b0);
        run_instr("or", 32'h0041_2825, 32'd9, 32'd100, 5'd5, 3'b011, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
